// File: rtl/aes_op_sequencer_if.sv
// Request/response handshake bundle between the host
// and the AES op sequencer.
interface aes_op_sequencer_if;
  logic         req_valid;
  logic         req_ready;
  logic         req_mode;
  logic [127:0] req_key;
  logic [127:0] req_text;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_mode;
  logic         rsp_err;

  modport master (
    output req_valid, req_mode, req_key, req_text,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_mode, rsp_err
  );

  modport slave (
    input  req_valid, req_mode, req_key, req_text,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_data, rsp_mode, rsp_err
  );
endinterface

// File: rtl/aes_op_sequencer.sv
// Single-request sequencer driving one AES encrypt core and
// one AES decrypt core, with a one-entry decrypt key cache.
module aes_op_sequencer #(
  parameter int KEXP_CYCLES    = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  aes_op_sequencer_if.slave  bus,
  output logic               enc_ld,
  output logic [127:0]       enc_key,
  output logic [127:0]       enc_text_in,
  input  logic [127:0]       enc_text_out,
  input  logic               enc_done,
  output logic               dec_kld,
  output logic               dec_ld,
  output logic [127:0]       dec_key,
  output logic [127:0]       dec_text_in,
  input  logic [127:0]       dec_text_out,
  input  logic               dec_done,
  output logic               busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ENC_LD   = 3'd1;
  localparam logic [2:0] ENC_WAIT = 3'd2;
  localparam logic [2:0] DEC_KLD  = 3'd3;
  localparam logic [2:0] DEC_KEXP = 3'd4;
  localparam logic [2:0] DEC_LD   = 3'd5;
  localparam logic [2:0] DEC_WAIT = 3'd6;
  localparam logic [2:0] RESP     = 3'd7;

  localparam int CMAX = (KEXP_CYCLES > TIMEOUT_CYCLES) ?
                        KEXP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] KEXP_LAST = CW'(KEXP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic          mode_q;
  logic [127:0]  key_q;
  logic [127:0]  text_q;
  logic [127:0]  cache_key;
  logic          cache_vld;
  logic [CW-1:0] cnt;
  logic [127:0]  data_q;
  logic          err_q;

  // Request capture, op sequencing, timeout and key cache
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      key_q     <= '0;
      text_q    <= '0;
      cache_key <= '0;
      cache_vld <= 1'b0;
      cnt       <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            mode_q <= bus.req_mode;
            key_q  <= bus.req_key;
            text_q <= bus.req_text;
            if (!bus.req_mode)
              state <= ENC_LD;
            else if (cache_vld && bus.req_key == cache_key)
              state <= DEC_LD;
            else
              state <= DEC_KLD;
          end
        end
        ENC_LD: begin
          cnt   <= '0;
          state <= ENC_WAIT;
        end
        ENC_WAIT: begin
          if (enc_done) begin
            data_q <= enc_text_out;
            err_q  <= 1'b0;
            state  <= RESP;
          end else if (cnt == TO_LAST) begin
            data_q <= '0;
            err_q  <= 1'b1;
            state  <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEC_KLD: begin
          cache_key <= key_q;
          cache_vld <= 1'b1;
          cnt       <= '0;
          state     <= DEC_KEXP;
        end
        DEC_KEXP: begin
          if (cnt == KEXP_LAST)
            state <= DEC_LD;
          else
            cnt <= cnt + 1'b1;
        end
        DEC_LD: begin
          cnt   <= '0;
          state <= DEC_WAIT;
        end
        DEC_WAIT: begin
          if (dec_done) begin
            data_q <= dec_text_out;
            err_q  <= 1'b0;
            state  <= RESP;
          end else if (cnt == TO_LAST) begin
            data_q    <= '0;
            err_q     <= 1'b1;
            cache_vld <= 1'b0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = data_q;
  assign bus.rsp_mode  = mode_q;
  assign bus.rsp_err   = err_q;

  assign enc_ld      = (state == ENC_LD);
  assign dec_kld     = (state == DEC_KLD);
  assign dec_ld      = (state == DEC_LD);
  assign enc_key     = key_q;
  assign enc_text_in = text_q;
  assign dec_key     = key_q;
  assign dec_text_in = text_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_aes_op_sequencer.sv
// Bench for aes_op_sequencer: behavioural AES core model,
// key-cache reference and timing checks per scenario.
module tb_aes_op_sequencer;

  localparam int K = 12;
  localparam int T = 64;
  localparam logic [127:0] FK =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enc_ld, dec_kld, dec_ld, busy;
  logic enc_done, dec_done;
  logic [127:0] enc_key, enc_text_in, enc_text_out;
  logic [127:0] dec_key, dec_text_in, dec_text_out;

  aes_op_sequencer_if bus();

  aes_op_sequencer #(
    .KEXP_CYCLES(K),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .enc_ld(enc_ld),
    .enc_key(enc_key),
    .enc_text_in(enc_text_in),
    .enc_text_out(enc_text_out),
    .enc_done(enc_done),
    .dec_kld(dec_kld),
    .dec_ld(dec_ld),
    .dec_key(dec_key),
    .dec_text_in(dec_text_in),
    .dec_text_out(dec_text_out),
    .dec_done(dec_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // core model knobs
  int lat = 2;
  bit nodone = 0;
  bit inj_enc = 0;
  bit inj_dec = 0;

  // core model state
  bit m_enc_done = 0, m_dec_done = 0;
  bit x_enc_done = 0, x_dec_done = 0;
  bit rst_q = 0;
  bit e_busy = 0, d_busy = 0, xvld = 0;
  int e_cnt = 0, d_cnt = 0;
  logic [127:0] e_res, d_res, xkey;

  assign enc_done = m_enc_done | x_enc_done;
  assign dec_done = m_dec_done | x_dec_done;

  // monitor records
  int n_acc = 0, n_enc_ld = 0, n_kld = 0, n_dec_ld = 0;
  int c_acc = 0, c_enc_ld = 0, c_kld = 0, c_dec_ld = 0;
  int c_done = 0, c_rsp = 0, c_hs = 0;
  bit overlap = 0;

  // reference key cache
  bit r_vld = 0;
  logic [127:0] r_key = '0;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] f_enc(
    input logic [127:0] k, input logic [127:0] t);
    if (k == FK && t == FP) return FC;
    return t ^ {k[63:0], k[127:64]} ^ 128'hc3;
  endfunction

  function automatic logic [127:0] f_dec(
    input logic [127:0] k, input logic [127:0] t);
    if (k == FK && t == FC) return FP;
    return t ^ {k[63:0], k[127:64]} ^ 128'hc3;
  endfunction

  // cycle counter and pulse monitor
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
    if (bus.req_valid && bus.req_ready) begin
      n_acc <= n_acc + 1;
      c_acc <= cyc;
    end
    if (enc_ld) begin
      n_enc_ld <= n_enc_ld + 1;
      c_enc_ld <= cyc;
    end
    if (dec_kld) begin
      n_kld <= n_kld + 1;
      c_kld <= cyc;
    end
    if (dec_ld) begin
      n_dec_ld <= n_dec_ld + 1;
      c_dec_ld <= cyc;
    end
    if (m_enc_done || m_dec_done) c_done <= cyc;
    if (enc_ld && (dec_ld || dec_kld)) overlap <= 1'b1;
  end

  // behavioural AES cores: fixed latency after ld, junk otherwise
  initial begin : core_model
    forever begin
      @(negedge clk);
      m_enc_done = 1'b0;
      m_dec_done = 1'b0;
      x_enc_done = inj_enc && (cyc % 2 == 1);
      x_dec_done = inj_dec && (cyc % 2 == 1);
      enc_text_out = rnd128();
      dec_text_out = rnd128();
      if (!rst_q) begin
        e_busy = 1'b0;
        d_busy = 1'b0;
        xvld   = 1'b0;
      end else begin
        if (e_busy) begin
          if (e_cnt == 0) begin
            m_enc_done   = 1'b1;
            enc_text_out = e_res;
            e_busy       = 1'b0;
          end else e_cnt--;
        end
        if (d_busy) begin
          if (d_cnt == 0) begin
            m_dec_done   = 1'b1;
            dec_text_out = d_res;
            d_busy       = 1'b0;
          end else d_cnt--;
        end
        if (enc_ld) begin
          e_busy = !nodone;
          e_cnt  = lat;
          e_res  = f_enc(enc_key, enc_text_in);
        end
        if (dec_kld) begin
          xkey = dec_key;
          xvld = 1'b1;
        end
        if (dec_ld) begin
          d_busy = !nodone;
          d_cnt  = lat;
          d_res  = xvld ? f_dec(xkey, dec_text_in) : 128'hbad;
        end
      end
    end
  end

  // drive one request, wait for its response (rsp_ready held low)
  task automatic issue(input bit mode, input logic [127:0] key,
                       input logic [127:0] text, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) return;
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    bus.req_key   = key;
    bus.req_text  = text;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_key   = rnd128();
    bus.req_text  = rnd128();
    n = 0;
    while (!bus.rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = bus.rsp_valid;
    c_rsp = cyc;
  endtask

  task automatic ack();
    c_hs = cyc;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_req_ready got %b exp 1", bus.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
    checks++; if ({enc_ld, dec_kld, dec_ld} !== 3'b000) begin errors++;
      $display("FAIL reset_pulses got %b exp 000",
               {enc_ld, dec_kld, dec_ld}); end
    checks++; if ({bus.rsp_err, bus.rsp_mode, bus.rsp_data} !== '0)
      begin errors++;
      $display("FAIL reset_rsp got %h exp 0", bus.rsp_data); end
    checks++; if (enc_key !== '0 || dec_text_in !== '0) begin errors++;
      $display("FAIL reset_core_regs got %h exp 0", enc_key); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_enc_fips();
    bit ok;
    int a0;
    lat = 3;
    a0 = n_enc_ld;
    issue(1'b0, FK, FP, ok);
    checks++; if (!ok) begin errors++;
      $display("FAIL enc_rsp got no rsp_valid exp rsp_valid"); end
    checks++; if (n_enc_ld - a0 !== 1) begin errors++;
      $display("FAIL enc_ld_count got %0d exp 1", n_enc_ld - a0); end
    checks++; if (c_enc_ld !== c_acc + 1) begin errors++;
      $display("FAIL enc_ld_lat got %0d exp %0d", c_enc_ld, c_acc + 1); end
    checks++; if (c_rsp !== c_done + 1) begin errors++;
      $display("FAIL enc_rsp_lat got %0d exp %0d", c_rsp, c_done + 1); end
    checks++; if (bus.rsp_data !== FC) begin errors++;
      $display("FAIL enc_data got %h exp %h", bus.rsp_data, FC); end
    checks++; if ({bus.rsp_err, bus.rsp_mode} !== 2'b00) begin errors++;
      $display("FAIL enc_err_mode got %b exp 00",
               {bus.rsp_err, bus.rsp_mode}); end
    checks++; if (enc_key !== FK || enc_text_in !== FP) begin errors++;
      $display("FAIL enc_key_hold got %h exp %h", enc_key, FK); end
    ack();
  endtask

  task automatic test_dec_miss();
    bit ok;
    int k0;
    lat = 2;
    k0 = n_kld;
    issue(1'b1, FK, FC, ok);
    r_vld = 1'b1;
    r_key = FK;
    checks++; if (!ok) begin errors++;
      $display("FAIL dmiss_rsp got no rsp_valid exp rsp_valid"); end
    checks++; if (n_kld - k0 !== 1) begin errors++;
      $display("FAIL dmiss_kld_count got %0d exp 1", n_kld - k0); end
    checks++; if (c_kld !== c_acc + 1) begin errors++;
      $display("FAIL dmiss_kld_lat got %0d exp %0d", c_kld, c_acc + 1); end
    checks++; if (c_dec_ld !== c_kld + K + 1) begin errors++;
      $display("FAIL dmiss_ld_lat got %0d exp %0d",
               c_dec_ld, c_kld + K + 1); end
    checks++; if (bus.rsp_data !== FP) begin errors++;
      $display("FAIL dmiss_data got %h exp %h", bus.rsp_data, FP); end
    checks++; if ({bus.rsp_err, bus.rsp_mode} !== 2'b01) begin errors++;
      $display("FAIL dmiss_err_mode got %b exp 01",
               {bus.rsp_err, bus.rsp_mode}); end
    checks++; if (c_rsp !== c_done + 1) begin errors++;
      $display("FAIL dmiss_rsp_lat got %0d exp %0d", c_rsp, c_done + 1); end
    ack();
  endtask

  task automatic test_dec_hit();
    bit ok;
    int k0;
    logic [127:0] nk, t;
    k0 = n_kld;
    issue(1'b1, FK, FC, ok);
    checks++; if (!ok || n_kld - k0 !== 0) begin errors++;
      $display("FAIL dhit_kld got %0d exp 0", n_kld - k0); end
    checks++; if (c_dec_ld !== c_acc + 1) begin errors++;
      $display("FAIL dhit_ld_lat got %0d exp %0d", c_dec_ld, c_acc + 1); end
    checks++; if (bus.rsp_data !== FP) begin errors++;
      $display("FAIL dhit_data got %h exp %h", bus.rsp_data, FP); end
    ack();
    nk = rnd128();
    t  = rnd128();
    k0 = n_kld;
    issue(1'b1, nk, t, ok);
    r_key = nk;
    checks++; if (!ok || n_kld - k0 !== 1) begin errors++;
      $display("FAIL dnew_kld got %0d exp 1", n_kld - k0); end
    checks++; if (bus.rsp_data !== f_dec(nk, t)) begin errors++;
      $display("FAIL dnew_data got %h exp %h",
               bus.rsp_data, f_dec(nk, t)); end
    ack();
  endtask

  task automatic test_timeout();
    bit ok;
    int k0;
    logic [127:0] t;
    nodone = 1'b1;
    inj_enc = 1'b1;
    t = rnd128();
    k0 = n_kld;
    issue(1'b1, r_key, t, ok);
    checks++; if (!ok || n_kld - k0 !== 0) begin errors++;
      $display("FAIL to_hit_kld got %0d exp 0", n_kld - k0); end
    checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_data !== '0)
      begin errors++;
      $display("FAIL to_err got err %b data %h exp err 1 data 0",
               bus.rsp_err, bus.rsp_data); end
    checks++; if (c_rsp !== c_dec_ld + 1 + T) begin errors++;
      $display("FAIL to_lat got %0d exp %0d", c_rsp, c_dec_ld + 1 + T); end
    nodone = 1'b0;
    inj_enc = 1'b0;
    r_vld = 1'b0;
    ack();
    t = rnd128();
    k0 = n_kld;
    issue(1'b1, r_key, t, ok);
    r_vld = 1'b1;
    checks++; if (!ok || n_kld - k0 !== 1) begin errors++;
      $display("FAIL to_rekld got %0d exp 1", n_kld - k0); end
    checks++; if (bus.rsp_data !== f_dec(r_key, t)) begin errors++;
      $display("FAIL to_redata got %h exp %h",
               bus.rsp_data, f_dec(r_key, t)); end
    ack();
  endtask

  task automatic test_backpressure();
    bit ok;
    int a0;
    logic [127:0] k, t, d0;
    k = rnd128();
    t = rnd128();
    lat = 6;
    inj_dec = 1'b1;
    issue(1'b0, k, t, ok);
    checks++; if (!ok || c_rsp !== c_done + 1) begin errors++;
      $display("FAIL bp_done_lat got %0d exp %0d", c_rsp, c_done + 1); end
    checks++; if (bus.rsp_data !== f_enc(k, t)) begin errors++;
      $display("FAIL bp_data got %h exp %h", bus.rsp_data, f_enc(k, t)); end
    a0 = n_acc;
    d0 = f_enc(k, t);
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = 1'b1;
      bus.req_mode  = 1'b1;
      bus.req_key   = rnd128();
      bus.req_text  = rnd128();
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== d0 ||
          bus.rsp_err !== 1'b0 || bus.rsp_mode !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v%b %h exp v1 %h",
                 i, bus.rsp_valid, bus.rsp_data, d0);
      end
      checks++; if (bus.req_ready !== 1'b0) begin errors++;
        $display("FAIL bp_req_ready cyc %0d got %b exp 0",
                 i, bus.req_ready); end
    end
    bus.req_valid = 1'b0;
    checks++; if (n_acc !== a0) begin errors++;
      $display("FAIL bp_accept got %0d exp %0d", n_acc, a0); end
    inj_dec = 1'b0;
    ack();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [127:0] t;
    lat = 1;
    t = rnd128();
    issue(1'b0, r_key, t, ok);
    ack();
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
      begin errors++;
      $display("FAIL b2b_idle got rdy %b vld %b exp rdy 1 vld 0",
               bus.req_ready, bus.rsp_valid); end
    t = rnd128();
    issue(1'b1, r_key, t, ok);
    checks++; if (!ok || c_acc !== c_hs + 1) begin errors++;
      $display("FAIL b2b_accept got %0d exp %0d", c_acc, c_hs + 1); end
    checks++; if (bus.rsp_data !== f_dec(r_key, t)) begin errors++;
      $display("FAIL b2b_data got %h exp %h",
               bus.rsp_data, f_dec(r_key, t)); end
    ack();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k0, d0;
    logic [127:0] nk, t;
    nk = rnd128();
    t  = rnd128();
    lat = 2;
    k0 = n_kld;
    bus.req_valid = 1'b1;
    bus.req_mode  = 1'b1;
    bus.req_key   = nk;
    bus.req_text  = t;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (n_kld - k0 !== 1 || busy !== 1'b1) begin errors++;
      $display("FAIL rmid_kld got %0d busy %b exp 1 busy 1",
               n_kld - k0, busy); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if ({busy, bus.req_ready, bus.rsp_valid} !== 3'b010)
      begin errors++;
      $display("FAIL rmid_state got %b exp 010",
               {busy, bus.req_ready, bus.rsp_valid}); end
    r_vld = 1'b0;
    d0 = n_dec_ld;
    repeat (20) @(negedge clk);
    checks++; if (n_dec_ld !== d0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_quiet got %0d exp %0d", n_dec_ld, d0); end
    k0 = n_kld;
    issue(1'b1, nk, t, ok);
    r_vld = 1'b1;
    r_key = nk;
    checks++; if (!ok || n_kld - k0 !== 1) begin errors++;
      $display("FAIL rmid_rekld got %0d exp 1", n_kld - k0); end
    checks++; if (bus.rsp_data !== f_dec(nk, t)) begin errors++;
      $display("FAIL rmid_data got %h exp %h",
               bus.rsp_data, f_dec(nk, t)); end
    ack();
  endtask

  task automatic test_random();
    bit ok, m, exp_kld;
    int k0;
    logic [127:0] pool [3];
    logic [127:0] key, t, exp_d;
    pool[0] = FK;
    pool[1] = rnd128();
    pool[2] = rnd128();
    for (int i = 0; i < 40; i++) begin
      m       = 1'($urandom_range(0, 1));
      key     = pool[$urandom_range(0, 2)];
      t       = rnd128();
      lat     = $urandom_range(0, 7);
      nodone  = m && ($urandom_range(0, 7) == 0);
      inj_enc = m && ($urandom_range(0, 1) == 1);
      inj_dec = !m && ($urandom_range(0, 1) == 1);
      exp_kld = m && !(r_vld && key == r_key);
      exp_d   = nodone ? '0 : (m ? f_dec(key, t) : f_enc(key, t));
      k0 = n_kld;
      issue(m, key, t, ok);
      checks++; if (!ok) begin errors++;
        $display("FAIL rnd_rsp op %0d got no rsp_valid exp rsp_valid", i);
      end
      checks++; if (n_kld - k0 !== int'(exp_kld)) begin errors++;
        $display("FAIL rnd_kld op %0d got %0d exp %0d",
                 i, n_kld - k0, exp_kld); end
      checks++; if (bus.rsp_data !== exp_d) begin errors++;
        $display("FAIL rnd_data op %0d got %h exp %h",
                 i, bus.rsp_data, exp_d); end
      checks++; if ({bus.rsp_err, bus.rsp_mode} !== {nodone, m}) begin
        errors++;
        $display("FAIL rnd_err_mode op %0d got %b exp %b",
                 i, {bus.rsp_err, bus.rsp_mode}, {nodone, m}); end
      if (exp_kld) begin
        r_vld = 1'b1;
        r_key = key;
      end
      if (m && nodone) r_vld = 1'b0;
      nodone  = 1'b0;
      inj_enc = 1'b0;
      inj_dec = 1'b0;
      ack();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_no_overlap();
    checks++; if (overlap !== 1'b0) begin errors++;
      $display("FAIL overlap got %b exp 0", overlap); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_mode  = 1'b0;
    bus.req_key   = '0;
    bus.req_text  = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_enc_fips();
    test_dec_miss();
    test_dec_hit();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_no_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1, "watchdog expired");
  end

endmodule
